adc_acq_capture_ctrl: RTL and testbench

Acquisition sequencer directly downstream of the ADC trigger block. It consumes trigger_out / trigger_sub_word and drives write-enable and a wrapping word address into the sample buffer. Each run is pre-trigger fill → wait for trigger → post-trigger fill → holdoff → done. It latches the exact trigger position (buffer word address + 3-bit sub-word) for software readback.

---
 rtl/adc_acq_pkg.sv | 29 ++
 rtl/adc_acq_edge_det.sv | 20 ++
 rtl/adc_acq_capture_ctrl.sv | 167 ++++++++++++++++
 tb/tb_adc_acq_capture_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition sequencer.
// State codes are visible on acq_state for status readback.
package adc_acq_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int LEN_W_DEF  = 24;
   localparam int HOLD_W_DEF = 32;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_POST = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_PRE  = ST_PRE,
      S_WAIT = ST_WAIT,
      S_POST = ST_POST,
      S_HOLD = ST_HOLD,
      S_DONE = ST_DONE
   } acq_state_e;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/adc_acq_edge_det.sv
// Registered rising-edge detector for the arm level.
// The edge is reported in the same cycle the level goes high.
module adc_acq_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic last;

   // remember the previous level every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last <= 1'b0;
      else        last <= din;
   end

   assign rise = din & ~last;

endmodule

// File: rtl/adc_acq_capture_ctrl.sv
// Acquisition sequencer: pre fill, wait trigger, post fill,
// holdoff, done; drives buffer writes and latches trigger position.
module adc_acq_capture_ctrl
   import adc_acq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF
) (
   input  logic              adc_data_clk,
   input  logic              adc_data_resetn,
   input  logic              acq_arm,
   input  logic              acq_abort,
   input  logic [LEN_W-1:0]  pre_len,
   input  logic [LEN_W-1:0]  post_len,
   input  logic [HOLD_W-1:0] holdoff_len,
   input  logic              trigger_in,
   input  logic [2:0]        trigger_sub_word_in,
   output logic              buf_wr_en,
   output logic [ADDR_W-1:0] buf_wr_addr,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [2:0]        trig_sub_word,
   output logic [2:0]        acq_state,
   output logic              acq_armed,
   output logic              acq_trig_seen,
   output logic              acq_done
);

   localparam int CNT_W = max_w(LEN_W, HOLD_W);

   acq_state_e        state;
   acq_state_e        nstate;
   logic [CNT_W-1:0]  cnt;
   logic [LEN_W-1:0]  pre_s;
   logic [LEN_W-1:0]  post_s;
   logic [HOLD_W-1:0] hold_s;
   logic              arm_edge;
   logic              run_load;
   logic              trig_take;
   logic              cnt_inc;
   logic              cnt_clr;
   logic              pre_last;
   logic              post_last;
   logic              hold_last;

   adc_acq_edge_det u_arm_edge (
      .clk   (adc_data_clk),
      .rst_n (adc_data_resetn),
      .din   (acq_arm),
      .rise  (arm_edge)
   );

   assign pre_last  = (cnt == (CNT_W'(pre_s) - CNT_W'(1)));
   assign post_last = (cnt == (CNT_W'(post_s) - CNT_W'(1)));
   assign hold_last = (hold_s == '0) ||
                      (cnt == (CNT_W'(hold_s) - CNT_W'(1)));

   // state register
   always_ff @(posedge adc_data_clk or negedge adc_data_resetn) begin
      if (!adc_data_resetn) state <= S_IDLE;
      else                  state <= nstate;
   end

   // next-state and datapath control; abort overrides everything
   always_comb begin
      nstate    = state;
      run_load  = 1'b0;
      trig_take = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      if (acq_abort) begin
         nstate = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (arm_edge) begin
                  run_load = 1'b1;
                  nstate   = (pre_len == '0) ? S_WAIT : S_PRE;
               end
            end
            S_PRE: begin
               cnt_inc = 1'b1;
               if (pre_last) nstate = S_WAIT;
            end
            S_WAIT: begin
               if (trigger_in) begin
                  trig_take = 1'b1;
                  cnt_clr   = 1'b1;
                  nstate    = (post_s == '0) ? S_HOLD : S_POST;
               end
            end
            S_POST: begin
               if (post_last) begin
                  cnt_clr = 1'b1;
                  nstate  = S_HOLD;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            S_HOLD: begin
               if (hold_last) nstate = S_DONE;
               else           cnt_inc = 1'b1;
            end
            default: nstate = S_IDLE;
         endcase
      end
   end

   // status decoded straight from the state register
   always_comb begin
      buf_wr_en = (state == S_PRE) || (state == S_WAIT) ||
                  (state == S_POST);
      acq_armed = (state == S_WAIT);
      acq_done  = (state == S_DONE);
      acq_state = state;
   end

   // run parameters are frozen at arm time
   always_ff @(posedge adc_data_clk or negedge adc_data_resetn) begin
      if (!adc_data_resetn) begin
         pre_s  <= '0;
         post_s <= '0;
         hold_s <= '0;
      end else if (run_load) begin
         pre_s  <= pre_len;
         post_s <= post_len;
         hold_s <= holdoff_len;
      end
   end

   // wrapping write address; frozen by abort
   always_ff @(posedge adc_data_clk or negedge adc_data_resetn) begin
      if (!adc_data_resetn)
         buf_wr_addr <= '0;
      else if (run_load)
         buf_wr_addr <= '0;
      else if (buf_wr_en && !acq_abort)
         buf_wr_addr <= buf_wr_addr + ADDR_W'(1);
   end

   // shared phase counter for pre, post and holdoff
   always_ff @(posedge adc_data_clk or negedge adc_data_resetn) begin
      if (!adc_data_resetn)
         cnt <= '0;
      else if (run_load || cnt_clr)
         cnt <= '0;
      else if (cnt_inc)
         cnt <= cnt + CNT_W'(1);
   end

   // trigger position latch and seen flag
   always_ff @(posedge adc_data_clk or negedge adc_data_resetn) begin
      if (!adc_data_resetn) begin
         trig_addr     <= '0;
         trig_sub_word <= '0;
         acq_trig_seen <= 1'b0;
      end else begin
         if (trig_take) begin
            trig_addr     <= buf_wr_addr;
            trig_sub_word <= trigger_sub_word_in;
         end
         if (acq_abort || run_load) acq_trig_seen <= 1'b0;
         else if (trig_take)        acq_trig_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_acq_capture_ctrl.sv
// Bench for adc_acq_capture_ctrl: directed table, corner
// sequences and random traffic against a timeline model.
module tb_adc_acq_capture_ctrl;

   localparam int AW = 4;
   localparam int LW = 24;
   localparam int HW = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [LW-1:0] pre = '0;
   logic [LW-1:0] post = '0;
   logic [HW-1:0] hold = '0;
   logic          trig = 1'b0;
   logic [2:0]    sub = '0;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [AW-1:0] taddr;
   logic [2:0]    tsub;
   logic [2:0]    st;
   logic          armed;
   logic          seen;
   logic          done;

   adc_acq_capture_ctrl #(.ADDR_W(AW), .LEN_W(LW), .HOLD_W(HW)) dut (
      .adc_data_clk        (clk),
      .adc_data_resetn     (rst_n),
      .acq_arm             (arm),
      .acq_abort           (abort),
      .pre_len             (pre),
      .post_len            (post),
      .holdoff_len         (hold),
      .trigger_in          (trig),
      .trigger_sub_word_in (sub),
      .buf_wr_en           (wen),
      .buf_wr_addr         (waddr),
      .trig_addr           (taddr),
      .trig_sub_word       (tsub),
      .acq_state           (st),
      .acq_armed           (armed),
      .acq_trig_seen       (seen),
      .acq_done            (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n = 0;

   // timeline model: a run is described by its arm cycle,
   // its trigger cycle and the captured lengths
   bit m_active;
   int m_tarm, m_tt, m_p, m_q, m_h;
   int m_frozen, m_taddr, m_tsub;
   bit m_seen, m_armlast;

   function automatic void m_reset();
      m_active = 0; m_tt = -1; m_frozen = 0;
      m_taddr = 0; m_tsub = 0; m_seen = 0; m_armlast = 0;
   endfunction

   function automatic int m_state(input int c);
      int e, d, hw;
      if (!m_active) return 0;
      e = c - m_tarm - 1;
      if (m_tt < 0) return (e < m_p) ? 1 : 2;
      d = c - m_tt - 1;
      hw = (m_h == 0) ? 1 : m_h;
      if (d < m_q) return 3;
      if (d < m_q + hw) return 4;
      return 5;
   endfunction

   function automatic int m_addr(input int c);
      int w, d;
      if (!m_active) return m_frozen;
      if (m_tt < 0) w = c - m_tarm - 1;
      else begin
         d = c - m_tt - 1;
         w = (m_tt - m_tarm) + ((d < m_q) ? d : m_q);
      end
      return w % DEPTH;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // compare this cycle against the model, then apply its events
   task automatic model_tick();
      int ms, ma;
      logic [17:0] act, exp;
      bit edge_hit;
      ms = m_state(n);
      ma = m_addr(n);
      exp = {3'(ms), (ms >= 1 && ms <= 3), AW'(ma), AW'(m_taddr),
             3'(m_tsub), m_seen, (ms == 2), (ms == 5)};
      act = {st, wen, waddr, taddr, tsub, seen, armed, done};
      chk($sformatf("model_cyc%0d", n), int'(act), int'(exp));
      edge_hit = arm & ~m_armlast;
      m_armlast = arm;
      if (abort) begin
         m_active = 0; m_frozen = ma; m_seen = 0;
      end else if ((ms == 0 || ms == 5) && edge_hit) begin
         m_active = 1; m_tarm = n; m_tt = -1; m_seen = 0;
         m_p = int'(pre); m_q = int'(post); m_h = int'(hold);
      end else if (ms == 2 && trig) begin
         m_tt = n; m_taddr = ma; m_tsub = int'(sub); m_seen = 1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   typedef struct {
      bit       arm;
      bit       trig;
      bit [2:0] sub;
      int       st;
      bit       wen;
      int       addr;
      int       taddr;
      int       tsub;
      bit       seen;
      bit       done;
   } vec_t;

   vec_t tbl[17];

   initial begin
      // pre=4 post=3 hold=5, trigger held from PRE onwards
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 1, 5, 1, 1, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 1, 5, 1, 1, 1, 0, 0, 0, 0};
      tbl[4]  = '{1, 1, 5, 1, 1, 2, 0, 0, 0, 0};
      tbl[5]  = '{1, 1, 5, 1, 1, 3, 0, 0, 0, 0};
      tbl[6]  = '{1, 1, 5, 2, 1, 4, 0, 0, 0, 0};
      tbl[7]  = '{1, 1, 2, 3, 1, 5, 4, 5, 1, 0};
      tbl[8]  = '{0, 1, 2, 3, 1, 6, 4, 5, 1, 0};
      tbl[9]  = '{0, 1, 2, 3, 1, 7, 4, 5, 1, 0};
      tbl[10] = '{0, 1, 2, 4, 0, 8, 4, 5, 1, 0};
      tbl[11] = '{0, 0, 0, 4, 0, 8, 4, 5, 1, 0};
      tbl[12] = '{0, 0, 0, 4, 0, 8, 4, 5, 1, 0};
      tbl[13] = '{0, 0, 0, 4, 0, 8, 4, 5, 1, 0};
      tbl[14] = '{0, 0, 0, 4, 0, 8, 4, 5, 1, 0};
      tbl[15] = '{0, 0, 0, 5, 0, 8, 4, 5, 1, 1};
      tbl[16] = '{0, 0, 0, 5, 0, 8, 4, 5, 1, 1};

      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {st, wen, waddr, seen, done}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      pre = 4; post = 3; hold = 5;
      for (int i = 0; i < 17; i++) begin
         arm = tbl[i].arm; trig = tbl[i].trig; sub = tbl[i].sub;
         if (i == 3) begin
            pre = 1; post = 1; hold = 0;
         end
         @(negedge clk);
         chk($sformatf("tbl_row%0d", i),
             {st, wen, waddr, taddr, tsub, seen, done},
             {3'(tbl[i].st), tbl[i].wen, AW'(tbl[i].addr),
              AW'(tbl[i].taddr), 3'(tbl[i].tsub), tbl[i].seen,
              tbl[i].done});
         model_tick();
         @(posedge clk);
         #1;
         n++;
      end

      // re-arm from DONE straight into WAIT
      pre = 0; post = 2; hold = 0; arm = 1;
      step();
      chk("rearm_state", st, 2);
      chk("rearm_addr", waddr, 0);
      chk("rearm_done", done, 0);
      steps(3);
      chk("arm_held_wait", st, 2);
      trig = 1; sub = 4;
      step();
      trig = 0;
      steps(3);
      chk("done_arm_high", st, 5);

      // trigger during PRE is ignored, next one in WAIT taken
      arm = 0;
      step();
      pre = 8; post = 1; hold = 0; arm = 1;
      step();
      steps(2);
      trig = 1; sub = 3;
      step();
      trig = 0;
      chk("pre_trig_seen", seen, 0);
      chk("pre_trig_state", st, 1);
      steps(5);
      chk("pre8_wait_addr", {st, waddr}, {3'd2, AW'(8)});
      trig = 1; sub = 6;
      step();
      trig = 0;
      chk("wait_trig_seen", seen, 1);
      chk("wait_trig_addr", taddr, 8);
      chk("wait_trig_sub", tsub, 6);
      steps(3);

      // long pre fill wraps the address; post=0 goes to HOLD
      arm = 0;
      step();
      pre = 20; post = 0; hold = 2; arm = 1;
      step();
      steps(20);
      chk("wrap_wait_addr", {st, waddr}, {3'd2, AW'(4)});
      steps(2);
      chk("wrap_addr6", waddr, 6);
      trig = 1; sub = 1;
      step();
      trig = 0;
      chk("wrap_trig_addr", taddr, 6);
      chk("post0_hold", st, 4);
      steps(3);

      // abort beats trigger in the same WAIT cycle
      arm = 0;
      step();
      pre = 2; post = 4; hold = 0; arm = 1;
      step();
      steps(2);
      abort = 1; trig = 1; sub = 7;
      step();
      abort = 0; trig = 0;
      chk("abort_state", st, 0);
      chk("abort_seen", seen, 0);
      chk("abort_taddr", {taddr, tsub}, {AW'(6), 3'd1});
      chk("abort_addr_hold", waddr, 2);

      // asynchronous reset in the middle of POST
      arm = 0;
      step();
      pre = 1; post = 5; hold = 0; arm = 1;
      step();
      step();
      trig = 1; sub = 2;
      step();
      trig = 0;
      step();
      chk("in_post", st, 3);
      rst_n = 1'b0;
      arm = 0;
      #2;
      chk("rst_async",
          {st, wen, waddr, taddr, tsub, seen, armed, done}, 0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) arm = ~arm;
         abort = ($urandom_range(0, 49) == 0);
         trig = ($urandom_range(0, 5) == 0);
         sub = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) pre = LW'($urandom_range(0, 20));
         if ($urandom_range(0, 9) == 0) post = LW'($urandom_range(0, 20));
         if ($urandom_range(0, 9) == 0) hold = HW'($urandom_range(0, 6));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
